// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared constants and types for the instruction memory
//
// Purpose: fault bit positions, the default fill/fault instruction and the
// fill state enum used by instruction_memory_sync.
package imem_pkg;

  // Bit positions inside rsp_fault
  localparam int FAULT_MISALIGN = 0;
  localparam int FAULT_RANGE    = 1;

  // addi x0, x0, 0
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } imem_state_t;

endpackage

// File: rtl/imem_ram.sv
// rtl/imem_ram.sv - DEPTH x XLEN array, one write port, one synchronous read port
//
// Purpose: storage for instruction_memory_sync. A read and a write to the same
// index in the same cycle returns the word held before the write.
// Ports:
//   clk          clock
//   we/waddr/wdata  write enable, word index, data
//   re/raddr     read enable, word index
//   rdata        registered read data; holds its value while re is low
module imem_ram #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [XLEN-1:0]          wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [XLEN-1:0]          rdata
);

  logic [XLEN-1:0] mem [DEPTH];

  // Both updates are non-blocking, so a same-edge read sees the old contents.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/instruction_memory_sync.sv
// rtl/instruction_memory_sync.sv - synchronous-read instruction memory with fill FSM
//
// Purpose: fetch port with valid/ready handshake and one-cycle latency, loader
// write port, and a post-reset fill that writes NOP_INSTR to every word.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   init_done             high once the fill has completed
//   req_valid/req_ready/req_pc                 fetch request
//   rsp_valid/rsp_ready/rsp_instruction/rsp_fault  fetch response
//   load_valid/load_ready/load_addr/load_data  loader write
module instruction_memory_sync
  import imem_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 256,
  parameter logic [XLEN-1:0] BASE_ADDR = '0,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(DEFAULT_NOP_INSTR)
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     init_done,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [XLEN-1:0]          req_pc,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [XLEN-1:0]          rsp_instruction,
  output logic [1:0]               rsp_fault,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [XLEN-1:0]          load_data
);

  localparam int AW = $clog2(DEPTH);

  imem_state_t     state;
  logic [AW-1:0]   cnt;
  logic            init_q;
  logic [XLEN-1:0] off;
  logic [XLEN-1:0] off_word;
  logic            misaligned;
  logic            out_of_range;
  logic [1:0]      fault;
  logic            req_fire;
  logic            load_fire;
  logic            rsp_from_ram;
  logic            ram_we;
  logic [AW-1:0]   ram_waddr;
  logic [XLEN-1:0] ram_wdata;
  logic [XLEN-1:0] ram_rdata;

  // Address decode. The range test uses the whole shifted offset so that PCs
  // far beyond the array cannot alias onto a valid index.
  assign off          = req_pc - BASE_ADDR;
  assign off_word     = off >> 2;
  assign misaligned   = req_pc[1:0] != 2'b00;
  assign out_of_range = off_word >= XLEN'(DEPTH);

  always_comb begin
    fault                 = '0;
    fault[FAULT_MISALIGN] = misaligned;
    fault[FAULT_RANGE]    = out_of_range;
  end

  assign init_done  = init_q;
  assign load_ready = init_q;
  // One-entry output register: a new request may enter when the slot is empty
  // or is being drained this cycle.
  assign req_ready  = init_q && (!rsp_valid || rsp_ready);
  assign req_fire   = req_valid && req_ready;
  assign load_fire  = load_valid && load_ready;

  // Write port belongs to the fill counter during INIT, to the loader after.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = load_addr;
    ram_wdata = load_data;
    if (state == INIT) begin
      ram_we    = 1'b1;
      ram_waddr = cnt;
      ram_wdata = NOP_INSTR;
    end else if (load_fire) begin
      ram_we = 1'b1;
    end
  end

  imem_ram #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (req_fire && (fault == 2'b00)),
    .raddr (off_word[AW-1:0]),
    .rdata (ram_rdata)
  );

  // Fill state machine
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= INIT;
      cnt    <= '0;
      init_q <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == AW'(DEPTH - 1)) begin
            state  <= READY;
            init_q <= 1'b1;
          end
        end
        READY: begin
          init_q <= 1'b1;
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

  // Response register. The RAM read register only updates on accepted,
  // fault-free requests, so it also holds steady through a stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid    <= 1'b0;
      rsp_fault    <= 2'b00;
      rsp_from_ram <= 1'b0;
    end else if (req_fire) begin
      rsp_valid    <= 1'b1;
      rsp_fault    <= fault;
      rsp_from_ram <= (fault == 2'b00);
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign rsp_instruction = rsp_from_ram ? ram_rdata : NOP_INSTR;

endmodule

// File: tb/tb_instruction_memory_sync.sv
// tb/tb_instruction_memory_sync.sv - scoreboard bench for instruction_memory_sync
module tb_instruction_memory_sync;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 8;
  localparam int          AW    = 3;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            init_done;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [XLEN-1:0] req_pc = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [XLEN-1:0] rsp_instruction;
  logic [1:0]      rsp_fault;
  logic            load_valid = 1'b0;
  logic            load_ready;
  logic [AW-1:0]   load_addr = '0;
  logic [XLEN-1:0] load_data = '0;

  always #5 clk = ~clk;

  instruction_memory_sync #(
    .XLEN      (XLEN),
    .DEPTH     (DEPTH),
    .BASE_ADDR (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .init_done       (init_done),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_pc          (req_pc),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_instruction (rsp_instruction),
    .rsp_fault       (rsp_fault),
    .load_valid      (load_valid),
    .load_ready      (load_ready),
    .load_addr       (load_addr),
    .load_data       (load_data)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [1:0]  fault;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: compare every response the consumer takes against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_instr", rsp_instruction, e.instr);
        check("rsp_fault", rsp_fault, e.fault);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the request is accepted.
  task automatic fetch(input logic [31:0] pc, input logic [31:0] ei, input logic [1:0] ef);
    int w;
    w = 0;
    req_valid = 1'b1;
    req_pc    = pc;
    @(negedge clk);
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) check("req_timeout", 64'd0, 64'd1);
    else sb.push_back({ei, ef});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [31:0] d);
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 20) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  // Releases reset on a falling edge and counts rising edges until init_done.
  task automatic release_and_time_init(input string name);
    int cycles;
    cycles = 0;
    @(negedge clk);
    reset = 1'b0;
    while (!init_done && cycles < 50) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check(name, 64'(cycles), 64'(DEPTH));
  endtask

  initial begin
    #1;
    check("rst_init_done", init_done, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_fault", rsp_fault, 0);
    check("rst_rsp_instr", rsp_instruction, NOP);
    check("rst_req_ready", req_ready, 0);
    check("rst_load_ready", load_ready, 0);
    @(posedge clk);
    release_and_time_init("init_cycles");
    check("ready_load_ready", load_ready, 1);

    for (int i = 0; i < DEPTH; i++) fetch(32'(i * 4), NOP, 2'b00);
    drain();

    load(3'd1, 32'h0090_0113);
    fetch(32'h4, 32'h0090_0113, 2'b00);
    fetch(32'h6, NOP, 2'b01);
    fetch(32'h20, NOP, 2'b10);
    fetch(32'h22, NOP, 2'b11);
    fetch(32'hFFFF_FFFC, NOP, 2'b10);
    fetch(32'h1C, NOP, 2'b00);
    drain();

    // Stall: response held while the consumer is not ready
    rsp_ready = 1'b0;
    fetch(32'h4, 32'h0090_0113, 2'b00);
    req_valid = 1'b1;
    req_pc    = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_req_ready", req_ready, 0);
      check("stall_rsp_valid", rsp_valid, 1);
      check("stall_rsp_instr", rsp_instruction, 32'h0090_0113);
      check("stall_rsp_fault", rsp_fault, 0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("unstall_req_ready", req_ready, 1);
    sb.push_back({NOP, 2'b00});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    drain();

    // Same-cycle load and fetch of word 2: old word first, new word after
    load_valid = 1'b1;
    load_addr  = 3'd2;
    load_data  = 32'hDEAD_BEEF;
    fetch(32'h8, NOP, 2'b00);
    load_valid = 1'b0;
    fetch(32'h8, 32'hDEAD_BEEF, 2'b00);
    drain();

    // Reset with a response pending
    rsp_ready = 1'b0;
    fetch(32'h4, 32'h0090_0113, 2'b00);
    #2;
    reset = 1'b1;
    #1;
    check("midfetch_rsp_valid", rsp_valid, 0);
    check("midfetch_init_done", init_done, 0);
    check("midfetch_rsp_instr", rsp_instruction, NOP);
    check("midfetch_req_ready", req_ready, 0);
    sb.delete();
    rsp_ready = 1'b1;

    // Reset again part way through the fill (cnt == 3)
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("midinit_init_done_pre", init_done, 0);
    reset = 1'b1;
    #1;
    check("midinit_init_done", init_done, 0);
    check("midinit_load_ready", load_ready, 0);
    release_and_time_init("refill_cycles");

    // The refill overwrote the loaded words
    fetch(32'h4, NOP, 2'b00);
    fetch(32'h8, NOP, 2'b00);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
